// File: rtl/grid_bank_arbiter_if.sv
// rtl/grid_bank_arbiter_if.sv - worker and host request/response bundle for grid_bank_arbiter
interface grid_bank_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_W      = 16,
    parameter int ROW_ADDR_W  = 8,
    parameter int COL_ADDR_W  = 8
);
    logic [NUM_CLIENTS-1:0]            cl_read_en;
    logic [NUM_CLIENTS-1:0]            cl_write_en;
    logic [NUM_CLIENTS*ROW_ADDR_W-1:0] cl_row_addr;
    logic [NUM_CLIENTS*COL_ADDR_W-1:0] cl_col_addr;
    logic [NUM_CLIENTS*DATA_W-1:0]     cl_wdata;
    logic [NUM_CLIENTS-1:0]            cl_ack;
    logic [DATA_W-1:0]                 rdata;
    logic                              host_req;
    logic                              host_we;
    logic [ROW_ADDR_W-1:0]             host_row_addr;
    logic [COL_ADDR_W-1:0]             host_col_addr;
    logic [DATA_W-1:0]                 host_wdata;
    logic                              host_ack;
    logic                              busy;

    modport master (
        output cl_read_en, cl_write_en, cl_row_addr, cl_col_addr, cl_wdata,
        output host_req, host_we, host_row_addr, host_col_addr, host_wdata,
        input  cl_ack, rdata, host_ack, busy
    );

    modport slave (
        input  cl_read_en, cl_write_en, cl_row_addr, cl_col_addr, cl_wdata,
        input  host_req, host_we, host_row_addr, host_col_addr, host_wdata,
        output cl_ack, rdata, host_ack, busy
    );
endinterface

// File: rtl/grid_bank_arbiter.sv
// rtl/grid_bank_arbiter.sv - grid row RAM with fixed-priority host and round-robin worker arbitration
module grid_bank_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_W      = 16,
    parameter int ROWS        = 140,
    parameter int ROW_BITS    = 144,
    parameter int ROW_ADDR_W  = 8,
    parameter int COL_ADDR_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    grid_bank_arbiter_if.slave   bus
);
    localparam int WORDS = ROW_BITS / DATA_W;
    localparam int DEPTH = ROWS * WORDS;
    localparam int AW    = $clog2(DEPTH);
    localparam int SHIFT = $clog2(DATA_W);
    localparam int CW    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [0:0] {IDLE, ACK} state_t;

    state_t                 state;
    logic [CW-1:0]          rr_ptr;
    logic [CW-1:0]          owner_q;
    logic                   owner_host_q;
    logic [NUM_CLIENTS-1:0] cl_ack_q;
    logic                   host_ack_q;
    logic                   busy_q;
    logic [DATA_W-1:0]      rdata_q;

    logic [DATA_W-1:0]      ram [DEPTH];

    logic [NUM_CLIENTS-1:0] cl_req;
    logic                   cl_found;
    logic [CW-1:0]          grant_idx;
    logic [CW-1:0]          cand;
    int                     scan;
    logic                   grant_valid;
    logic                   sel_we;
    logic [ROW_ADDR_W-1:0]  sel_row;
    logic [COL_ADDR_W-1:0]  sel_col;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   addr_ok;
    logic [AW-1:0]          ram_addr;
    logic                   ram_we;

    assign cl_req = bus.cl_read_en | bus.cl_write_en;

    always_comb begin
        cl_found  = 1'b0;
        grant_idx = '0;
        cand      = '0;
        scan      = 0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= NUM_CLIENTS) scan = scan - NUM_CLIENTS;
            cand = CW'(scan);
            if (!cl_found && cl_req[cand]) begin
                cl_found  = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_valid = bus.host_req | cl_found;

    // Host outranks every worker; the round-robin scan only matters when the host is quiet.
    always_comb begin
        sel_we    = bus.host_we;
        sel_row   = bus.host_row_addr;
        sel_col   = bus.host_col_addr;
        sel_wdata = bus.host_wdata;
        if (!bus.host_req) begin
            sel_we    = bus.cl_write_en[grant_idx];
            sel_row   = bus.cl_row_addr[grant_idx*ROW_ADDR_W +: ROW_ADDR_W];
            sel_col   = bus.cl_col_addr[grant_idx*COL_ADDR_W +: COL_ADDR_W];
            sel_wdata = bus.cl_wdata[grant_idx*DATA_W +: DATA_W];
        end
    end

    // Columns past the end of a row are rejected like bad rows so they never alias the next row.
    assign addr_ok  = (int'(sel_row) < ROWS) && (int'(sel_col >> SHIFT) < WORDS);
    assign ram_addr = AW'(sel_row) * AW'(WORDS) + AW'(sel_col >> SHIFT);
    assign ram_we   = (state == IDLE) && grant_valid && sel_we && addr_ok;

    always_ff @(posedge clock) begin
        if (ram_we) ram[ram_addr] <= sel_wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner_q      <= '0;
            owner_host_q <= 1'b0;
            cl_ack_q     <= '0;
            host_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner_host_q <= bus.host_req;
                        owner_q      <= grant_idx;
                        busy_q       <= 1'b1;
                        if (sel_we)       rdata_q <= sel_wdata;
                        else if (addr_ok) rdata_q <= ram[ram_addr];
                        else              rdata_q <= '0;
                        if (bus.host_req) host_ack_q <= 1'b1;
                        else              cl_ack_q   <= NUM_CLIENTS'(1) << grant_idx;
                        state <= ACK;
                    end
                end
                ACK: begin
                    cl_ack_q   <= '0;
                    host_ack_q <= 1'b0;
                    busy_q     <= 1'b0;
                    if (!owner_host_q)
                        rr_ptr <= (owner_q == CW'(NUM_CLIENTS - 1)) ? '0 : owner_q + CW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cl_ack   = cl_ack_q;
    assign bus.host_ack = host_ack_q;
    assign bus.busy     = busy_q;
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_grid_bank_arbiter.sv
// tb/tb_grid_bank_arbiter.sv - directed self-checking bench for grid_bank_arbiter
module tb_grid_bank_arbiter;
    localparam int NC = 4;
    localparam int DW = 16;
    localparam int RW = 8;
    localparam int CLW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    grid_bank_arbiter_if #(.NUM_CLIENTS(NC), .DATA_W(DW), .ROW_ADDR_W(RW), .COL_ADDR_W(CLW)) bus ();

    grid_bank_arbiter #(
        .NUM_CLIENTS(NC), .DATA_W(DW), .ROWS(140), .ROW_BITS(144),
        .ROW_ADDR_W(RW), .COL_ADDR_W(CLW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        bus.cl_read_en    = '0;
        bus.cl_write_en   = '0;
        bus.cl_row_addr   = '0;
        bus.cl_col_addr   = '0;
        bus.cl_wdata      = '0;
        bus.host_req      = 1'b0;
        bus.host_we       = 1'b0;
        bus.host_row_addr = '0;
        bus.host_col_addr = '0;
        bus.host_wdata    = '0;
    endtask

    task automatic set_host(input logic we, input logic [RW-1:0] row,
                            input logic [CLW-1:0] col, input logic [DW-1:0] wd);
        bus.host_req      = 1'b1;
        bus.host_we       = we;
        bus.host_row_addr = row;
        bus.host_col_addr = col;
        bus.host_wdata    = wd;
    endtask

    task automatic set_client(input int c, input logic rd, input logic wr, input logic [RW-1:0] row,
                              input logic [CLW-1:0] col, input logic [DW-1:0] wd);
        bus.cl_read_en[c]              = rd;
        bus.cl_write_en[c]             = wr;
        bus.cl_row_addr[c*RW +: RW]    = row;
        bus.cl_col_addr[c*CLW +: CLW]  = col;
        bus.cl_wdata[c*DW +: DW]       = wd;
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.cl_ack !== 4'b0000) begin miscompares++; $display("FAIL reset_cl_ack got %b exp 0000", bus.cl_ack); end
        vectors++;
        if (bus.host_ack !== 1'b0) begin miscompares++; $display("FAIL reset_host_ack got %b exp 0", bus.host_ack); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        vectors++;
        if (bus.rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_rdata got %h exp 0000", bus.rdata); end
    endtask

    // All four workers read an out-of-range row so rdata is a known 0 each ack.
    task automatic test_round_robin();
        logic [NC-1:0] exp_ack;
        for (int c = 0; c < NC; c++) set_client(c, 1'b1, 1'b0, 8'd250, 8'd0, 16'h0);
        for (int i = 0; i < 2*NC; i++) begin
            tick();
            exp_ack = (i % 2 == 0) ? (4'b0001 << (i / 2)) : 4'b0000;
            vectors++;
            if (bus.cl_ack !== exp_ack) begin miscompares++; $display("FAIL rr_ack_%0d got %b exp %b", i, bus.cl_ack, exp_ack); end
            vectors++;
            if (bus.busy !== (i % 2 == 0)) begin miscompares++; $display("FAIL rr_busy_%0d got %b exp %b", i, bus.busy, (i % 2 == 0)); end
        end
        clear_inputs();
    endtask

    task automatic test_host_rw();
        set_host(1'b1, 8'd3, 8'd32, 16'hA5A5);
        tick();
        vectors++;
        if (bus.host_ack !== 1'b1) begin miscompares++; $display("FAIL hw_host_ack got %b exp 1", bus.host_ack); end
        vectors++;
        if (bus.cl_ack !== 4'b0000) begin miscompares++; $display("FAIL hw_cl_ack got %b exp 0000", bus.cl_ack); end
        vectors++;
        if (bus.rdata !== 16'hA5A5) begin miscompares++; $display("FAIL hw_rdata got %h exp a5a5", bus.rdata); end
        clear_inputs();
        tick();
        vectors++;
        if (bus.host_ack !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL hw_idle got ack=%b busy=%b exp 0 0", bus.host_ack, bus.busy);
        end
        set_host(1'b0, 8'd3, 8'd32, 16'h0);
        tick();
        vectors++;
        if (bus.host_ack !== 1'b1) begin miscompares++; $display("FAIL hr_host_ack got %b exp 1", bus.host_ack); end
        vectors++;
        if (bus.rdata !== 16'hA5A5) begin miscompares++; $display("FAIL hr_rdata got %h exp a5a5", bus.rdata); end
        clear_inputs();
        tick();
    endtask

    // Client 2 raises read_en and write_en together; it must behave as a write.
    task automatic test_misaligned();
        set_client(2, 1'b1, 1'b1, 8'd5, 8'd17, 16'h00FF);
        tick();
        vectors++;
        if (bus.cl_ack !== 4'b0100) begin miscompares++; $display("FAIL mis_ack got %b exp 0100", bus.cl_ack); end
        clear_inputs();
        tick();
        set_host(1'b0, 8'd5, 8'd16, 16'h0);
        tick();
        vectors++;
        if (bus.rdata !== 16'h00FF) begin miscompares++; $display("FAIL mis_rdata got %h exp 00ff", bus.rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_host_priority();
        set_host(1'b0, 8'd3, 8'd32, 16'h0);
        set_client(1, 1'b1, 1'b0, 8'd5, 8'd16, 16'h0);
        tick();
        vectors++;
        if (bus.host_ack !== 1'b1 || bus.cl_ack !== 4'b0000) begin
            miscompares++; $display("FAIL pri_t1 got host=%b cl=%b exp 1 0000", bus.host_ack, bus.cl_ack);
        end
        bus.host_req = 1'b0;
        tick();
        vectors++;
        if (bus.cl_ack !== 4'b0000) begin miscompares++; $display("FAIL pri_t2 got %b exp 0000", bus.cl_ack); end
        tick();
        vectors++;
        if (bus.cl_ack !== 4'b0010) begin miscompares++; $display("FAIL pri_t3 got %b exp 0010", bus.cl_ack); end
        vectors++;
        if (bus.rdata !== 16'h00FF) begin miscompares++; $display("FAIL pri_rdata got %h exp 00ff", bus.rdata); end
        clear_inputs();
        tick();
        // rr_ptr is now 2; a lone host grant must not move it, so client 3 beats client 1.
        set_host(1'b0, 8'd3, 8'd32, 16'h0);
        tick();
        clear_inputs();
        tick();
        set_client(1, 1'b1, 1'b0, 8'd250, 8'd0, 16'h0);
        set_client(3, 1'b1, 1'b0, 8'd250, 8'd0, 16'h0);
        tick();
        vectors++;
        if (bus.cl_ack !== 4'b1000) begin miscompares++; $display("FAIL pri_rr_first got %b exp 1000", bus.cl_ack); end
        tick();
        tick();
        vectors++;
        if (bus.cl_ack !== 4'b0010) begin miscompares++; $display("FAIL pri_rr_second got %b exp 0010", bus.cl_ack); end
        clear_inputs();
        tick();
    endtask

    task automatic test_out_of_range();
        set_host(1'b0, 8'd3, 8'd32, 16'h0);
        tick();
        clear_inputs();
        tick();
        set_client(0, 1'b1, 1'b0, 8'd200, 8'd0, 16'h0);
        tick();
        vectors++;
        if (bus.cl_ack !== 4'b0001) begin miscompares++; $display("FAIL oor_rd_ack got %b exp 0001", bus.cl_ack); end
        vectors++;
        if (bus.rdata !== 16'h0000) begin miscompares++; $display("FAIL oor_rd_rdata got %h exp 0000", bus.rdata); end
        clear_inputs();
        tick();
        set_client(0, 1'b0, 1'b1, 8'd200, 8'd32, 16'h1234);
        tick();
        vectors++;
        if (bus.cl_ack !== 4'b0001) begin miscompares++; $display("FAIL oor_wr_ack got %b exp 0001", bus.cl_ack); end
        clear_inputs();
        tick();
        set_host(1'b0, 8'd3, 8'd32, 16'h0);
        tick();
        vectors++;
        if (bus.rdata !== 16'hA5A5) begin miscompares++; $display("FAIL oor_keep_r3 got %h exp a5a5", bus.rdata); end
        clear_inputs();
        tick();
        set_host(1'b0, 8'd5, 8'd16, 16'h0);
        tick();
        vectors++;
        if (bus.rdata !== 16'h00FF) begin miscompares++; $display("FAIL oor_keep_r5 got %h exp 00ff", bus.rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_ack();
        set_client(2, 1'b1, 1'b0, 8'd250, 8'd0, 16'h0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.cl_ack !== 4'b0000 || bus.busy !== 1'b0 || bus.host_ack !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid got cl=%b busy=%b host=%b exp 0000 0 0", bus.cl_ack, bus.busy, bus.host_ack);
        end
        clear_inputs();
        @(negedge clock);
        for (int c = 0; c < NC; c++) set_client(c, 1'b1, 1'b0, 8'd250, 8'd0, 16'h0);
        tick();
        vectors++;
        if (bus.cl_ack !== 4'b0000) begin miscompares++; $display("FAIL rst_hold got %b exp 0000", bus.cl_ack); end
        reset = 1'b0;
        tick();
        vectors++;
        if (bus.cl_ack !== 4'b0001) begin miscompares++; $display("FAIL rst_restart got %b exp 0001", bus.cl_ack); end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_round_robin();
        test_host_rw();
        test_misaligned();
        test_host_priority();
        test_out_of_range();
        test_reset_mid_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
